// File: rtl/ahb_cmd_master_if.sv
// Command stream and AHB-Lite bus signals of ahb_cmd_master.
// The master modport is the initiator's view. The slave modport is the view of the command source and responder.
interface ahb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYOUT, HRDATA, HRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADYOUT, HRDATA, HRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY
  );
endinterface

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator that issues single-beat word transfers from a valid/ready command stream.
// The address phase (A stage) overlaps the data phase (D stage). Each command gets one response pulse.
module ahb_cmd_master (
    input logic HCLK,
    input logic HRESET,
    ahb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    logic        rst_hold_q;
    logic        a_valid_q, a_valid_d;
    logic        a_write_q, a_write_d;
    logic [31:0] a_addr_q, a_addr_d;
    logic [31:0] a_wdata_q, a_wdata_d;
    logic        d_valid_q, d_valid_d;
    logic        d_write_q, d_write_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        addr_go;
    logic        data_done;
    logic        cmd_take;
    htrans_e     htrans;

    // HRESP high means the first or second cycle of an error response.
    // The pending address phase is withdrawn and stays in A to be reissued.
    assign htrans    = (a_valid_q && !bus.HRESP) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign addr_go   = a_valid_q && bus.HREADYOUT && !bus.HRESP;
    assign data_done = d_valid_q && bus.HREADYOUT;
    assign cmd_take  = bus.cmd_valid && bus.cmd_ready;

    assign bus.cmd_ready = !HRESET && !rst_hold_q && (!a_valid_q || (bus.HREADYOUT && !bus.HRESP));
    assign bus.HTRANS    = htrans;
    assign bus.HSEL      = (htrans == HTRANS_NONSEQ);
    assign bus.HADDR     = a_addr_q;
    assign bus.HWRITE    = a_write_q;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HWDATA    = d_wdata_q;
    assign bus.HREADY    = bus.HREADYOUT;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_write_d   = a_write_q;
        a_addr_d    = a_addr_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        rsp_valid_d = data_done;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (cmd_take) begin
            a_valid_d = 1'b1;
            a_write_d = bus.cmd_write;
            a_addr_d  = {bus.cmd_addr[31:2], 2'b00};
            a_wdata_d = bus.cmd_wdata;
        end else if (addr_go) begin
            a_valid_d = 1'b0;
        end

        if (addr_go) begin
            d_valid_d = 1'b1;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
        end else if (data_done) begin
            d_valid_d = 1'b0;
        end

        if (data_done) begin
            rsp_write_d = d_write_q;
            rsp_rdata_d = d_write_q ? '0 : bus.HRDATA;
            rsp_err_d   = bus.HRESP;
        end
    end

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rst_hold_q <= 1'b1;
        end else begin
            rst_hold_q <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule
